// File: rtl/timer_counter_pkg.sv
// Shared constants for the timer/counter: FSM states, register offsets, MODE codes, CTRL bits.
// Latency: n/a (constants only); backpressure: n/a.
package timer_counter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_CNT  = 2'd2,
    ST_INT  = 2'd3
  } tc_state_e;

  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_PRESET = 2'd1;
  localparam logic [1:0] ADDR_COUNT  = 2'd2;
  localparam logic [1:0] ADDR_RSVD   = 2'd3;

  localparam logic [1:0] MODE_ONESHOT = 2'b00;
  localparam logic [1:0] MODE_RELOAD  = 2'b01;

  localparam int CTRL_EN_BIT   = 0;
  localparam int CTRL_MODE_LSB = 1;
  localparam int CTRL_IM_BIT   = 3;

  function automatic logic [31:0] ctrl_word(input logic en, input logic [1:0] mode, input logic im);
    logic [31:0] w;
    w = 32'd0;
    w[CTRL_EN_BIT]             = en;
    w[CTRL_MODE_LSB +: 2]      = mode;
    w[CTRL_IM_BIT]             = im;
    return w;
  endfunction

endpackage

// File: rtl/timer_counter.sv
// Memory-mapped down-counting timer with one-shot/auto-reload modes and a maskable interrupt.
// Latency: irq rises N+2 edges after EN is written (N=PRESET, 0 acts as 1); backpressure: none, bus always accepts.
module timer_counter
  import timer_counter_pkg::*;
#(
  parameter logic [31:0] RESET_PRESET = 32'd0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sel,
  input  logic [1:0]  addr,
  input  logic [3:0]  byteen,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq
);

  tc_state_e   state_q, state_d;
  logic        en_q, en_d;
  logic [1:0]  mode_q;
  logic        im_q;
  logic [31:0] preset_q;
  logic [31:0] count_q, count_d;
  logic        flag_q, flag_d;

  logic wr_ok, ctrl_wr, preset_wr;

  assign wr_ok     = sel && (byteen == 4'b1111);
  assign ctrl_wr   = wr_ok && (addr == ADDR_CTRL);
  assign preset_wr = wr_ok && (addr == ADDR_PRESET);

  always_comb begin
    state_d = state_q;
    en_d    = en_q;
    count_d = count_q;
    flag_d  = flag_q;
    case (state_q)
      ST_IDLE: begin
        if (en_q) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        count_d = preset_q;
        state_d = ST_CNT;
      end
      ST_CNT: begin
        if (!en_q) begin
          state_d = ST_IDLE;
        end else if (count_q > 32'd1) begin
          count_d = count_q - 32'd1;
        end else begin
          count_d = 32'd0;
          flag_d  = 1'b1;
          state_d = ST_INT;
        end
      end
      ST_INT: begin
        if (mode_q == MODE_RELOAD) begin
          flag_d  = 1'b0;
          state_d = ST_LOAD;
        end else begin
          en_d    = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // Bus writes take precedence over the FSM's own EN/FLAG updates.
    if (ctrl_wr) en_d = wdata[CTRL_EN_BIT];
    if (ctrl_wr || preset_wr) flag_d = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      en_q     <= 1'b0;
      mode_q   <= MODE_ONESHOT;
      im_q     <= 1'b0;
      preset_q <= RESET_PRESET;
      count_q  <= 32'd0;
      flag_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      en_q    <= en_d;
      count_q <= count_d;
      flag_q  <= flag_d;
      if (ctrl_wr) begin
        mode_q <= wdata[CTRL_MODE_LSB +: 2];
        im_q   <= wdata[CTRL_IM_BIT];
      end
      if (preset_wr) preset_q <= wdata;
    end
  end

  always_comb begin
    rdata = 32'd0;
    case (addr)
      ADDR_CTRL:   rdata = ctrl_word(en_q, mode_q, im_q);
      ADDR_PRESET: rdata = preset_q;
      ADDR_COUNT:  rdata = count_q;
      ADDR_RSVD:   rdata = 32'd0;
      default:     rdata = 32'd0;
    endcase
  end

  assign irq = flag_q & im_q;

endmodule

// File: tb/tb_timer_counter.sv
// Scoreboard bench: stimulus pushes predicted {rdata,irq}; a negedge monitor pops and compares.
module tb_timer_counter;

  localparam logic [31:0] TB_RESET_PRESET = 32'd3;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        sel = 1'b0;
  logic [1:0]  addr = 2'd0;
  logic [3:0]  byteen = 4'd0;
  logic [31:0] wdata = 32'd0;
  logic [31:0] rdata;
  logic        irq;

  timer_counter #(.RESET_PRESET(TB_RESET_PRESET)) dut (
    .clk(clk), .reset(reset), .sel(sel), .addr(addr), .byteen(byteen),
    .wdata(wdata), .rdata(rdata), .irq(irq)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  logic [32:0] exp_q[$];
  string       tag_q[$];

  // Reference model: architectural registers plus a run timeline in absolute edge numbers.
  logic        m_en, m_im, m_flag;
  logic [1:0]  m_mode;
  logic [31:0] m_preset, m_count;
  bit          busy;
  int          edge_no = 0;
  int          t0;
  longint      n_run;

  function automatic void model_reset();
    m_en = 0; m_im = 0; m_flag = 0; m_mode = 2'b00;
    m_preset = TB_RESET_PRESET; m_count = 0;
    busy = 0; t0 = 0; n_run = 0;
  endfunction

  function automatic logic [31:0] m_rdata(input logic [1:0] a);
    case (a)
      2'd0:    return {28'd0, m_im, m_mode, m_en};
      2'd1:    return m_preset;
      2'd2:    return m_count;
      default: return 32'd0;
    endcase
  endfunction

  // Timeline of a run starting when EN is seen: edge t0 loads PRESET, edges t0+1..t0+ne
  // count down (expiry at t0+ne, ne = max(N,1)), edge t0+ne+1 ends or reloads the run.
  function automatic void model_edge(input logic s, input logic [1:0] a,
                                     input logic [3:0] be, input logic [31:0] wd);
    logic nen, nflag;
    logic [31:0] ncount;
    longint ne;
    edge_no++;
    nen = m_en; nflag = m_flag; ncount = m_count;
    if (!busy) begin
      if (m_en) begin busy = 1; t0 = edge_no + 1; end
    end else if (edge_no == t0) begin
      n_run = longint'(m_preset); ncount = m_preset;
    end else begin
      ne = (n_run < 1) ? 1 : n_run;
      if (longint'(edge_no) <= longint'(t0) + ne) begin
        if (!m_en) busy = 0;
        else if (longint'(edge_no) == longint'(t0) + ne) begin ncount = 0; nflag = 1; end
        else ncount = 32'(n_run - longint'(edge_no - t0));
      end else if (m_mode == 2'b01) begin
        nflag = 0; t0 = edge_no + 1;
      end else begin
        nen = 0; busy = 0;
      end
    end
    if (s && be == 4'hF) begin
      if (a == 2'd0) begin nen = wd[0]; m_mode = wd[2:1]; m_im = wd[3]; nflag = 0; end
      else if (a == 2'd1) begin m_preset = wd; nflag = 0; end
    end
    m_en = nen; m_flag = nflag; m_count = ncount;
  endfunction

  // Called at posedge+1: drive the cycle's bus inputs, predict, then advance one edge.
  task automatic tick(input logic s, input logic [1:0] a, input logic [3:0] be,
                      input logic [31:0] wd, input string tg);
    sel = s; addr = a; byteen = be; wdata = wd;
    exp_q.push_back({m_rdata(a), m_flag & m_im});
    tag_q.push_back(tg);
    @(posedge clk);
    if (!reset) model_reset();
    else model_edge(s, a, be, wd);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d, input string tg);
    tick(1'b1, a, 4'hF, d, tg);
  endtask

  task automatic rd(input logic [1:0] a, input int n, input string tg);
    for (int i = 0; i < n; i++) tick(1'b0, a, 4'hF, 32'hDEAD_BEEF, tg);
  endtask

  task automatic set_reset(input logic v);
    reset = v;
    if (!v) model_reset();
  endtask

  always @(negedge clk) begin
    logic [32:0] e;
    string tg;
    if (exp_q.size() > 0) begin
      e  = exp_q.pop_front();
      tg = tag_q.pop_front();
      n_tests++;
      if ({rdata, irq} !== e) begin
        n_fail++;
        $display("FAIL %s: addr=%0d rdata=%h irq=%b, required rdata=%h irq=%b",
                 tg, addr, rdata, irq, e[32:1], e[0]);
      end
    end
  end

  initial begin
    int r;
    logic [1:0] a;
    model_reset();
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) tick(1'b0, 2'(i), 4'h0, 32'd0, "reset_state");
    set_reset(1'b1);

    // One-shot, PRESET=5, IM=1
    wr(2'd1, 32'd5, "oneshot_preset"); wr(2'd0, 32'h9, "oneshot_start");
    rd(2'd2, 10, "oneshot_count"); rd(2'd0, 2, "oneshot_ctrl");
    // Auto-reload, PRESET=3
    wr(2'd1, 32'd3, "reload_preset"); wr(2'd0, 32'hB, "reload_start");
    rd(2'd2, 16, "reload_count"); wr(2'd0, 32'h0, "reload_stop");
    // Masked one-shot, then CTRL write clears FLAG
    wr(2'd1, 32'd2, "mask_preset"); wr(2'd0, 32'h1, "mask_start");
    rd(2'd2, 6, "mask_count"); wr(2'd0, 32'h8, "mask_unmask"); rd(2'd0, 3, "mask_irq");
    // Bus rules
    wr(2'd1, 32'd7, "bus_preset");
    tick(1'b1, 2'd1, 4'b0011, 32'hFFFF, "bus_partial"); rd(2'd1, 1, "bus_partial_rd");
    wr(2'd2, 32'h55, "bus_wr_count"); rd(2'd2, 1, "bus_count_rd"); rd(2'd3, 1, "bus_rsvd");
    wr(2'd0, 32'hFFFF_FFFF, "bus_ctrl_ones"); rd(2'd0, 1, "bus_ctrl_rd"); rd(2'd2, 12, "bus_mode11");
    // PRESET=0 behaves like 1
    wr(2'd1, 32'd0, "p0_preset"); wr(2'd0, 32'h9, "p0_start"); rd(2'd0, 6, "p0_run");
    // CTRL write on the same edge INT clears EN
    wr(2'd1, 32'd2, "race_preset"); wr(2'd0, 32'h9, "race_start");
    rd(2'd0, 4, "race_run"); wr(2'd0, 32'h9, "race_write"); rd(2'd0, 8, "race_after");
    // PRESET rewrite mid-count in auto-reload
    wr(2'd0, 32'h0, "mid_stop"); rd(2'd0, 2, "mid_idle");
    wr(2'd1, 32'd4, "mid_preset"); wr(2'd0, 32'hB, "mid_start"); rd(2'd2, 3, "mid_count");
    wr(2'd1, 32'd9, "mid_rewrite"); rd(2'd2, 20, "mid_next_run");
    // EN=0 stops and EN=1 reloads
    wr(2'd1, 32'd6, "stop_preset"); wr(2'd0, 32'h9, "stop_start"); rd(2'd2, 4, "stop_count");
    wr(2'd0, 32'h8, "stop_en0"); rd(2'd2, 3, "stop_held");
    wr(2'd0, 32'h9, "stop_restart"); rd(2'd2, 5, "stop_reload");
    // Reset mid-count at COUNT=4
    wr(2'd1, 32'd6, "rst_preset"); wr(2'd0, 32'h9, "rst_start"); rd(2'd2, 4, "rst_count");
    set_reset(1'b0); rd(2'd2, 1, "rst_async");
    rd(2'd0, 1, "rst_ctrl"); rd(2'd1, 1, "rst_preset_rd"); rd(2'd3, 1, "rst_rsvd");
    set_reset(1'b1); rd(2'd2, 6, "rst_idle"); rd(2'd0, 1, "rst_ctrl_after");

    // Randomized traffic
    for (int i = 0; i < 500; i++) begin
      r = int'($urandom_range(0, 199));
      a = 2'($urandom_range(0, 3));
      if (r < 14)      wr(2'd0, 32'($urandom_range(0, 15)), "rnd_ctrl");
      else if (r < 24) wr(2'd1, 32'($urandom_range(0, 6)), "rnd_preset");
      else if (r < 32) tick(1'b1, a, 4'($urandom_range(0, 14)), $urandom, "rnd_partial");
      else if (r < 36) wr(2'($urandom_range(2, 3)), $urandom, "rnd_ro");
      else if (r == 199) begin
        set_reset(1'b0); rd(a, 1, "rnd_reset"); set_reset(1'b1);
      end else tick(1'($urandom_range(0, 1)), a, 4'($urandom_range(0, 14)), $urandom, "rnd_idle");
    end

    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      n_tests++; n_fail++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
